// File: rtl/apb_i2cs_msg_regs.sv
// I2C-slave APB register block with two byte message FIFOs.
// APB->I2C (a2i) and I2C->APB (i2a) buffers, status, flush and irq.
module apb_i2cs_msg_regs #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      apb_pclk_i,
    input  logic                      apb_presetn_i,
    input  logic [APB_ADDR_WIDTH-1:0] apb_reg_waddr_i,
    input  logic [31:0]               apb_reg_wdata_i,
    input  logic                      apb_reg_wrenable_i,
    input  logic [APB_ADDR_WIDTH-1:0] apb_reg_raddr_i,
    output logic [31:0]               apb_reg_rdata_o,
    input  logic                      apb_reg_rd_byte_complete_i,
    output logic                      i2c_rx_valid_o,
    output logic [7:0]                i2c_rx_data_o,
    input  logic                      i2c_rx_pop_i,
    input  logic                      i2c_tx_push_i,
    input  logic [7:0]                i2c_tx_data_i,
    output logic                      i2c_tx_full_o,
    output logic                      irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

    localparam logic [APB_ADDR_WIDTH-1:0] A_ID  = APB_ADDR_WIDTH'(12'h000);
    localparam logic [APB_ADDR_WIDTH-1:0] A_ENA = APB_ADDR_WIDTH'(12'h004);
    localparam logic [APB_ADDR_WIDTH-1:0] A_A2I = APB_ADDR_WIDTH'(12'h008);
    localparam logic [APB_ADDR_WIDTH-1:0] A_I2A = APB_ADDR_WIDTH'(12'h00C);
    localparam logic [APB_ADDR_WIDTH-1:0] A_STS = APB_ADDR_WIDTH'(12'h010);
    localparam logic [APB_ADDR_WIDTH-1:0] A_FLS = APB_ADDR_WIDTH'(12'h014);
    localparam logic [APB_ADDR_WIDTH-1:0] A_IEN = APB_ADDR_WIDTH'(12'h018);

    logic                      en_q;
    logic [1:0]                int_en_q;
    logic                      ovf_q;
    logic                      udf_q;
    logic                      irq_q;
    logic [APB_ADDR_WIDTH-1:0] raddr_q;
    logic                      rdc_q;

    logic [7:0]    a_mem [FIFO_DEPTH];
    logic [7:0]    i_mem [FIFO_DEPTH];
    logic [PW-1:0] a_wp, a_rp, i_wp, i_rp;
    logic [4:0]    a_cnt, i_cnt;

    logic wr_ena, wr_a2i, wr_sts, wr_fls, wr_ien;
    logic a_empty, a_full, i_empty, i_full;
    logic a_flush, i_flush;
    logic a_pop_req, a_pop, a_push;
    logic i_push_req, i_pop_req, i_pop, i_push;
    logic ovf_set, udf_set, irq_d;
    logic [7:0]  a_head, i_head;
    logic [31:0] status;
    logic        unused_wdata;

    assign unused_wdata = ^apb_reg_wdata_i[31:8];

    assign wr_ena = apb_reg_wrenable_i & (apb_reg_waddr_i == A_ENA);
    assign wr_a2i = apb_reg_wrenable_i & (apb_reg_waddr_i == A_A2I);
    assign wr_sts = apb_reg_wrenable_i & (apb_reg_waddr_i == A_STS);
    assign wr_fls = apb_reg_wrenable_i & (apb_reg_waddr_i == A_FLS);
    assign wr_ien = apb_reg_wrenable_i & (apb_reg_waddr_i == A_IEN);

    assign a_empty = (a_cnt == 5'd0);
    assign a_full  = (a_cnt == DEPTH);
    assign i_empty = (i_cnt == 5'd0);
    assign i_full  = (i_cnt == DEPTH);

    assign a_flush = wr_fls & apb_reg_wdata_i[0];
    assign i_flush = wr_fls & apb_reg_wdata_i[1];

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // alongside a pop is accepted.
    assign a_pop_req = en_q & i2c_rx_pop_i;
    assign a_pop     = a_pop_req & ~a_empty;
    assign a_push    = wr_a2i & (~a_full | a_pop);

    // Only the rising edge of read-complete pops, so long pulses pop once.
    assign i_push_req = en_q & i2c_tx_push_i;
    assign i_pop_req  = apb_reg_rd_byte_complete_i & ~rdc_q
                      & (raddr_q == A_I2A);
    assign i_pop      = i_pop_req & ~i_empty;
    assign i_push     = i_push_req & (~i_full | i_pop);

    assign ovf_set = (wr_a2i & ~a_push & ~a_flush)
                   | (i_push_req & ~i_push & ~i_flush);
    assign udf_set = i_pop_req & i_empty;
    assign irq_d   = en_q & ((int_en_q[0] & ~i_empty)
                           | (int_en_q[1] & a_empty));

    assign a_head = a_empty ? 8'h00 : a_mem[a_rp];
    assign i_head = i_empty ? 8'h00 : i_mem[i_rp];

    assign status = {16'h0, i_cnt[3:0], a_cnt[3:0], 2'b00, udf_q, ovf_q,
                     i_full, i_empty, a_full, a_empty};

    assign i2c_rx_valid_o = en_q & ~a_empty;
    assign i2c_rx_data_o  = a_head;
    assign i2c_tx_full_o  = ~en_q | i_full;
    assign irq_o          = irq_q;

    // Combinational read mux driven by the raw APB read address.
    always_comb begin
        apb_reg_rdata_o = 32'h0;
        case (apb_reg_raddr_i)
            A_ID:    apb_reg_rdata_o = 32'h1235_0001;
            A_ENA:   apb_reg_rdata_o = {31'h0, en_q};
            A_I2A:   apb_reg_rdata_o = {24'h0, i_head};
            A_STS:   apb_reg_rdata_o = status;
            A_IEN:   apb_reg_rdata_o = {30'h0, int_en_q};
            default: apb_reg_rdata_o = 32'h0;
        endcase
    end

    // Control registers, sticky flags, read-side pipeline and irq.
    always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
        if (!apb_presetn_i) begin
            en_q     <= 1'b0;
            int_en_q <= 2'b00;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_q    <= 1'b0;
            raddr_q  <= '0;
            rdc_q    <= 1'b0;
        end else begin
            if (wr_ena) en_q <= apb_reg_wdata_i[0];
            if (wr_ien) int_en_q <= apb_reg_wdata_i[1:0];
            ovf_q   <= (ovf_q & ~(wr_sts & apb_reg_wdata_i[4])) | ovf_set;
            udf_q   <= (udf_q & ~(wr_sts & apb_reg_wdata_i[5])) | udf_set;
            irq_q   <= irq_d;
            raddr_q <= apb_reg_raddr_i;
            rdc_q   <= apb_reg_rd_byte_complete_i;
        end
    end

    // FIFO pointers and counts; a flush overrides any push or pop.
    always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
        if (!apb_presetn_i) begin
            a_wp  <= '0;
            a_rp  <= '0;
            a_cnt <= 5'd0;
            i_wp  <= '0;
            i_rp  <= '0;
            i_cnt <= 5'd0;
        end else begin
            if (a_flush) begin
                a_wp  <= '0;
                a_rp  <= '0;
                a_cnt <= 5'd0;
            end else begin
                if (a_push) a_wp <= a_wp + 1'b1;
                if (a_pop) a_rp <= a_rp + 1'b1;
                a_cnt <= a_cnt + {4'd0, a_push} - {4'd0, a_pop};
            end
            if (i_flush) begin
                i_wp  <= '0;
                i_rp  <= '0;
                i_cnt <= 5'd0;
            end else begin
                if (i_push) i_wp <= i_wp + 1'b1;
                if (i_pop) i_rp <= i_rp + 1'b1;
                i_cnt <= i_cnt + {4'd0, i_push} - {4'd0, i_pop};
            end
        end
    end

    // FIFO storage is not reset; only accepted pushes write it.
    always_ff @(posedge apb_pclk_i) begin
        if (a_push & ~a_flush) a_mem[a_wp] <= apb_reg_wdata_i[7:0];
        if (i_push & ~i_flush) i_mem[i_wp] <= i2c_tx_data_i;
    end

endmodule
